// File: rtl/scr1_mem_arb_pkg.sv
// IMEM/DMEM arbiter package: FSM state and bus owner encodings.
package scr1_mem_arb_pkg;

    localparam int unsigned SCR1_ARB_CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/scr1_memif_pkg.sv
// Memory interface types shared by the core's memory-side blocks.
// Command, access width and response encodings.
package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_mem_arb.sv
// Two-to-one IMEM/DMEM arbiter onto a unified memory port.
// DMEM has priority; IMEM is forced through after a run of losses.
module scr1_mem_arb
    import scr1_memif_pkg::*;
    import scr1_mem_arb_pkg::*;
#(
    parameter int unsigned SCR1_ARB_STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_req_i,
    input  logic [31:0]          imem_addr_i,
    output logic                 imem_req_ack_o,
    output logic [31:0]          imem_rdata_o,
    output type_scr1_mem_resp_e  imem_resp_o,
    input  logic                 dmem_req_i,
    input  type_scr1_mem_cmd_e   dmem_cmd_i,
    input  type_scr1_mem_width_e dmem_width_i,
    input  logic [31:0]          dmem_addr_i,
    input  logic [31:0]          dmem_wdata_i,
    output logic                 dmem_req_ack_o,
    output logic [31:0]          dmem_rdata_o,
    output type_scr1_mem_resp_e  dmem_resp_o,
    output logic                 mem_req_o,
    output type_scr1_mem_cmd_e   mem_cmd_o,
    output type_scr1_mem_width_e mem_width_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_req_ack_i,
    input  logic [31:0]          mem_rdata_i,
    input  type_scr1_mem_resp_e  mem_resp_i
);

    localparam logic [SCR1_ARB_CNT_W-1:0] LIM =
        SCR1_ARB_CNT_W'(SCR1_ARB_STARVE_LIM);

    arb_state_e                state_q, state_d;
    arb_owner_e                owner_q, owner_d;
    arb_owner_e                sel;
    logic [SCR1_ARB_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                      owner_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign owner_req = (owner_q == OWN_IMEM) ? imem_req_i
                     : (owner_q == OWN_DMEM) ? dmem_req_i : 1'b0;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        starve_cnt_d   = starve_cnt_q;
        sel            = OWN_NONE;
        imem_req_ack_o = 1'b0;
        imem_rdata_o   = '0;
        imem_resp_o    = SCR1_MEM_RESP_NOTRDY;
        dmem_req_ack_o = 1'b0;
        dmem_rdata_o   = '0;
        dmem_resp_o    = SCR1_MEM_RESP_NOTRDY;
        mem_req_o      = 1'b0;
        mem_cmd_o      = SCR1_MEM_CMD_RD;
        mem_width_o    = SCR1_MEM_WIDTH_BYTE;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        // Outputs are held quiet while reset is asserted, even with requests up
        if (rst_n) begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (imem_req_i || dmem_req_i) begin
                        sel = (imem_req_i && (!dmem_req_i || starve_cnt_q == LIM))
                            ? OWN_IMEM : OWN_DMEM;
                    end
                end
                ARB_REQ: begin
                    if (owner_req) begin
                        sel = owner_q;
                    end else begin
                        state_d = ARB_IDLE;
                        owner_d = OWN_NONE;
                    end
                end
                ARB_RESP: begin
                    if (owner_q == OWN_IMEM) begin
                        imem_resp_o  = mem_resp_i;
                        imem_rdata_o = mem_rdata_i;
                    end else if (owner_q == OWN_DMEM) begin
                        dmem_resp_o  = mem_resp_i;
                        dmem_rdata_o = mem_rdata_i;
                    end
                    if (mem_resp_i == SCR1_MEM_RESP_RDY_OK ||
                        mem_resp_i == SCR1_MEM_RESP_RDY_ER) begin
                        state_d = ARB_IDLE;
                        owner_d = OWN_NONE;
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                    owner_d = OWN_NONE;
                end
            endcase

            if (sel == OWN_IMEM) begin
                mem_req_o      = 1'b1;
                mem_cmd_o      = SCR1_MEM_CMD_RD;
                mem_width_o    = SCR1_MEM_WIDTH_WORD;
                mem_addr_o     = imem_addr_i;
                imem_req_ack_o = mem_req_ack_i;
            end else if (sel == OWN_DMEM) begin
                mem_req_o      = 1'b1;
                mem_cmd_o      = dmem_cmd_i;
                mem_width_o    = dmem_width_i;
                mem_addr_o     = dmem_addr_i;
                mem_wdata_o    = dmem_wdata_i;
                dmem_req_ack_o = mem_req_ack_i;
            end

            if (sel != OWN_NONE) begin
                owner_d = sel;
                if (mem_req_ack_i) begin
                    state_d = ARB_RESP;
                    if (sel == OWN_IMEM) begin
                        starve_cnt_d = '0;
                    end else if (imem_req_i && starve_cnt_q < LIM) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ARB_REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_scr1_mem_arb.sv
// Directed bench for scr1_mem_arb with hand-computed expectations.
module tb_scr1_mem_arb;
    import scr1_memif_pkg::*;
    import scr1_mem_arb_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 imem_req_i;
    logic [31:0]          imem_addr_i;
    logic                 imem_req_ack_o;
    logic [31:0]          imem_rdata_o;
    type_scr1_mem_resp_e  imem_resp_o;
    logic                 dmem_req_i;
    type_scr1_mem_cmd_e   dmem_cmd_i;
    type_scr1_mem_width_e dmem_width_i;
    logic [31:0]          dmem_addr_i;
    logic [31:0]          dmem_wdata_i;
    logic                 dmem_req_ack_o;
    logic [31:0]          dmem_rdata_o;
    type_scr1_mem_resp_e  dmem_resp_o;
    logic                 mem_req_o;
    type_scr1_mem_cmd_e   mem_cmd_o;
    type_scr1_mem_width_e mem_width_o;
    logic [31:0]          mem_addr_o;
    logic [31:0]          mem_wdata_o;
    logic                 mem_req_ack_i;
    logic [31:0]          mem_rdata_i;
    type_scr1_mem_resp_e  mem_resp_i;

    int checks = 0;
    int errors = 0;

    scr1_mem_arb #(.SCR1_ARB_STARVE_LIM(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_i     (imem_req_i),
        .imem_addr_i    (imem_addr_i),
        .imem_req_ack_o (imem_req_ack_o),
        .imem_rdata_o   (imem_rdata_o),
        .imem_resp_o    (imem_resp_o),
        .dmem_req_i     (dmem_req_i),
        .dmem_cmd_i     (dmem_cmd_i),
        .dmem_width_i   (dmem_width_i),
        .dmem_addr_i    (dmem_addr_i),
        .dmem_wdata_i   (dmem_wdata_i),
        .dmem_req_ack_o (dmem_req_ack_o),
        .dmem_rdata_o   (dmem_rdata_o),
        .dmem_resp_o    (dmem_resp_o),
        .mem_req_o      (mem_req_o),
        .mem_cmd_o      (mem_cmd_o),
        .mem_width_o    (mem_width_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_req_ack_i  (mem_req_ack_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_resp_i     (mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        string exp_pat;
        string got_pat;

        rst_n         = 1'b0;
        imem_req_i    = 1'b0;
        imem_addr_i   = '0;
        dmem_req_i    = 1'b0;
        dmem_cmd_i    = SCR1_MEM_CMD_RD;
        dmem_width_i  = SCR1_MEM_WIDTH_WORD;
        dmem_addr_i   = '0;
        dmem_wdata_i  = '0;
        mem_req_ack_i = 1'b0;
        mem_rdata_i   = '0;
        mem_resp_i    = SCR1_MEM_RESP_NOTRDY;

        // Reset state, including requests held during reset
        #12;
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_imem_resp", 32'(imem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
        chk("rst_dmem_resp", 32'(dmem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
        chk("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
        imem_req_i    = 1'b1;
        dmem_req_i    = 1'b1;
        mem_req_ack_i = 1'b1;
        settle();
        chk("rst_req_held_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_req_held_dmem_ack", 32'(dmem_req_ack_o), 32'd0);
        imem_req_i    = 1'b0;
        dmem_req_i    = 1'b0;
        mem_req_ack_i = 1'b0;

        // Both requesters in the same cycle with ack
        tick();
        rst_n         = 1'b1;
        settle();
        chk("idle_mem_addr_zero", mem_addr_o, 32'h0);
        dmem_req_i    = 1'b1;
        dmem_addr_i   = 32'h200;
        imem_req_i    = 1'b1;
        imem_addr_i   = 32'h40;
        mem_req_ack_i = 1'b1;
        settle();
        chk("both_mem_addr", mem_addr_o, 32'h200);
        chk("both_dmem_ack", 32'(dmem_req_ack_o), 32'd1);
        chk("both_imem_ack", 32'(imem_req_ack_o), 32'd0);
        tick();
        chk("both_starve", 32'(dut.starve_cnt_q), 32'd1);
        chk("resp_mem_req_low", 32'(mem_req_o), 32'd0);
        imem_req_i    = 1'b0;
        dmem_req_i    = 1'b0;
        mem_req_ack_i = 1'b0;
        mem_resp_i    = SCR1_MEM_RESP_RDY_OK;
        mem_rdata_i   = 32'h1111_2222;
        settle();
        chk("both_dmem_rdata", dmem_rdata_o, 32'h1111_2222);
        chk("both_imem_rdata", imem_rdata_o, 32'h0);
        chk("both_imem_resp", 32'(imem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
        tick();

        // Fairness: D,D,D,D,I repeating with immediate ack and response
        pulse_reset();
        imem_req_i    = 1'b1;
        dmem_req_i    = 1'b1;
        mem_req_ack_i = 1'b1;
        mem_resp_i    = SCR1_MEM_RESP_RDY_OK;
        mem_rdata_i   = 32'h0;
        exp_pat = "DDDDIDDDDI";
        got_pat = "";
        for (int i = 0; i < 10; i++) begin
            settle();
            if (dmem_req_ack_o && !imem_req_ack_o)      got_pat = {got_pat, "D"};
            else if (imem_req_ack_o && !dmem_req_ack_o) got_pat = {got_pat, "I"};
            else                                        got_pat = {got_pat, "x"};
            tick();
            tick();
        end
        checks++;
        assert (got_pat == exp_pat) else begin
            errors++;
            $error("FAIL grant_pattern observed=%s expected=%s", got_pat, exp_pat);
        end
        imem_req_i    = 1'b0;
        dmem_req_i    = 1'b0;
        mem_req_ack_i = 1'b0;
        mem_resp_i    = SCR1_MEM_RESP_NOTRDY;
        pulse_reset();

        // DMEM held in REQ without ack; grant must not move to IMEM
        dmem_req_i  = 1'b1;
        dmem_cmd_i  = SCR1_MEM_CMD_RD;
        dmem_addr_i = 32'h100;
        tick();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h80;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("hold_addr_%0d", i), mem_addr_o, 32'h100);
            chk($sformatf("hold_req_%0d", i), 32'(mem_req_o), 32'd1);
            tick();
        end
        mem_req_ack_i = 1'b1;
        settle();
        chk("hold_dmem_ack", 32'(dmem_req_ack_o), 32'd1);
        chk("hold_imem_ack", 32'(imem_req_ack_o), 32'd0);
        tick();
        mem_req_ack_i = 1'b0;
        dmem_req_i    = 1'b0;
        mem_resp_i    = SCR1_MEM_RESP_RDY_OK;
        mem_rdata_i   = 32'hDEAD_BEEF;
        settle();
        chk("hold_dmem_rdata", dmem_rdata_o, 32'hDEAD_BEEF);
        chk("hold_dmem_resp", 32'(dmem_resp_o), 32'(SCR1_MEM_RESP_RDY_OK));
        chk("hold_imem_rdata", imem_rdata_o, 32'h0);
        chk("hold_starve", 32'(dut.starve_cnt_q), 32'd1);
        tick();

        // IMEM alone wins; error response goes to IMEM only
        mem_resp_i    = SCR1_MEM_RESP_NOTRDY;
        mem_rdata_i   = 32'h0;
        mem_req_ack_i = 1'b1;
        settle();
        chk("imem_ack", 32'(imem_req_ack_o), 32'd1);
        chk("imem_addr", mem_addr_o, 32'h80);
        chk("imem_width", 32'(mem_width_o), 32'(SCR1_MEM_WIDTH_WORD));
        chk("imem_cmd", 32'(mem_cmd_o), 32'(SCR1_MEM_CMD_RD));
        tick();
        chk("imem_starve_clr", 32'(dut.starve_cnt_q), 32'd0);
        imem_req_i    = 1'b0;
        mem_req_ack_i = 1'b0;
        mem_resp_i    = SCR1_MEM_RESP_RDY_ER;
        settle();
        chk("err_imem_resp", 32'(imem_resp_o), 32'(SCR1_MEM_RESP_RDY_ER));
        chk("err_dmem_resp", 32'(dmem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
        tick();
        chk("err_back_idle", 32'(dut.state_q), 32'(ARB_IDLE));
        chk("err_idle_imem_resp", 32'(imem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));

        // Reset in RESP: outputs drop without a clock edge
        mem_resp_i    = SCR1_MEM_RESP_NOTRDY;
        dmem_req_i    = 1'b1;
        mem_req_ack_i = 1'b1;
        tick();
        dmem_req_i    = 1'b0;
        mem_req_ack_i = 1'b0;
        mem_resp_i    = SCR1_MEM_RESP_RDY_OK;
        mem_rdata_i   = 32'h0000_1234;
        settle();
        chk("pre_rst_rdata", dmem_rdata_o, 32'h0000_1234);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdata", dmem_rdata_o, 32'h0);
        chk("async_rst_resp", 32'(dmem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
        chk("async_rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
        rst_n = 1'b1;
        #1;
        chk("post_rst_dmem_resp", 32'(dmem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
        tick();
        chk("post_rst_edge_resp", 32'(dmem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
        chk("post_rst_imem_resp", 32'(imem_resp_o), 32'(SCR1_MEM_RESP_NOTRDY));
        mem_resp_i = SCR1_MEM_RESP_NOTRDY;

        // DMEM write abandoned in REQ, IMEM picks up next cycle
        dmem_req_i   = 1'b1;
        dmem_cmd_i   = SCR1_MEM_CMD_WR;
        dmem_wdata_i = 32'hCAFE_F00D;
        dmem_addr_i  = 32'h300;
        imem_req_i   = 1'b1;
        imem_addr_i  = 32'h84;
        settle();
        chk("wr_cmd", 32'(mem_cmd_o), 32'(SCR1_MEM_CMD_WR));
        chk("wr_wdata", mem_wdata_o, 32'hCAFE_F00D);
        tick();
        dmem_req_i = 1'b0;
        settle();
        chk("drop_mem_req", 32'(mem_req_o), 32'd0);
        tick();
        mem_req_ack_i = 1'b1;
        settle();
        chk("drop_imem_req", 32'(mem_req_o), 32'd1);
        chk("drop_imem_addr", mem_addr_o, 32'h84);
        chk("drop_imem_ack", 32'(imem_req_ack_o), 32'd1);
        tick();
        imem_req_i    = 1'b0;
        mem_req_ack_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
